// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - machine word type and shared instruction constants
package cpu_types_pkg;
    localparam int unsigned WBITS = 32;
    typedef logic [WBITS-1:0] word_t;
    localparam word_t NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/pipe_types_pkg.sv
// rtl/pipe_types_pkg.sv - IF/ID latch layout and fetch state encoding
package pipe_types_pkg;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic  valid;
        word_t instr;
        word_t pc;
        word_t npc;
    } ifid_t;

    typedef enum logic [1:0] {
        FETCH         = 2'd0,
        REDIRECT_WAIT = 2'd1,
        HALTED        = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_stats_ctr.sv
// rtl/fetch_stats_ctr.sv - saturating event counter, holds at all-ones
module fetch_stats_ctr #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner, imem request driver and IF/ID latch
// Optional build macro FETCH_STATS_EN adds stall/flush counters.
module fetch_stage
    import cpu_types_pkg::*;
    import pipe_types_pkg::*;
#(
    parameter word_t PC_INIT      = 32'h0000_0000,
    parameter word_t NOP_INSTR_P  = NOP_INSTR
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  ifid_stall,
    input  logic  flushed,
    input  word_t redirect_pc,
    input  logic  halt,
    output logic  ifid_valid,
    output word_t ifid_instr,
    output word_t ifid_pc,
    output word_t ifid_npc,
    output word_t stall_cycles,
    output word_t flush_count
);
    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pend_pc_q, pend_pc_d;
    ifid_t        ifid_q, ifid_d;
    ifid_t        bubble;

    // A bubble keeps the old pc/npc; only valid and the instruction word change.
    always_comb begin
        bubble       = ifid_q;
        bubble.valid = 1'b0;
        bubble.instr = NOP_INSTR_P;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        ifid_d    = ifid_q;
        unique case (state_q)
            FETCH: begin
                if (halt) begin
                    state_d = HALTED;
                    ifid_d  = bubble;
                end else if (flushed) begin
                    ifid_d = bubble;
                    if (ihit) begin
                        pc_d = redirect_pc;
                    end else begin
                        pend_pc_d = redirect_pc;
                        state_d   = REDIRECT_WAIT;
                    end
                end else if (ifid_stall) begin
                    ifid_d = ifid_q;
                end else if (ihit) begin
                    ifid_d = '{valid: 1'b1, instr: imemload, pc: pc_q, npc: pc_q + 32'd4};
                    pc_d   = pc_q + 32'd4;
                end else begin
                    ifid_d = bubble;
                end
            end
            REDIRECT_WAIT: begin
                ifid_d = bubble;
                if (halt) begin
                    state_d = HALTED;
                end else if (flushed && ihit) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (flushed) begin
                    pend_pc_d = redirect_pc;
                end else if (ihit) begin
                    pc_d    = pend_pc_q;
                    state_d = FETCH;
                end
            end
            default: begin
                ifid_d = bubble;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= FETCH;
            pc_q      <= PC_INIT;
            pend_pc_q <= '0;
            ifid_q    <= '{valid: 1'b0, instr: NOP_INSTR_P, pc: '0, npc: '0};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            ifid_q    <= ifid_d;
        end
    end

    assign imemREN    = (state_q != HALTED);
    assign imemaddr   = pc_q;
    assign ifid_valid = ifid_q.valid;
    assign ifid_instr = ifid_q.instr;
    assign ifid_pc    = ifid_q.pc;
    assign ifid_npc   = ifid_q.npc;

`ifdef FETCH_STATS_EN
    logic stall_inc, flush_inc;
    assign stall_inc = (state_q == FETCH) && ifid_stall && !flushed;
    assign flush_inc = (state_q != HALTED) && flushed;

    fetch_stats_ctr #(.W(WBITS)) u_stall_ctr (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (stall_inc),
        .count_o (stall_cycles)
    );

    fetch_stats_ctr #(.W(WBITS)) u_flush_ctr (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (flush_inc),
        .count_o (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed-vector bench for fetch_stage
module tb_fetch_stage;
    logic        CLK = 1'b0;
    logic        nRST, ihit, imemREN, ifid_stall, flushed, halt, ifid_valid;
    logic [31:0] imemload, imemaddr, redirect_pc, ifid_instr, ifid_pc, ifid_npc;
    logic [31:0] stall_cycles, flush_count;
    int          n_vec = 0;
    int          n_bad = 0;

    fetch_stage dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .ifid_stall(ifid_stall),
        .flushed(flushed), .redirect_pc(redirect_pc), .halt(halt),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_npc(ifid_npc), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic h, input logic s, input logic f,
                         input logic [31:0] rpc, input logic hl);
        ihit        = h;
        ifid_stall  = s;
        flushed     = f;
        redirect_pc = rpc;
        halt        = hl;
        imemload    = 32'hA500_0000 ^ imemaddr;
    endtask

    initial begin
        nRST = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0ABC, 1'b1);
        step();
        step();
        chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_pc", ifid_pc, 32'h0);
        chk("rst_npc", ifid_npc, 32'h0);
        chk("rst_addr", imemaddr, 32'h0);
        chk("rst_ren", {31'b0, imemREN}, 32'd1);
        chk("rst_stall_ctr", stall_cycles, 32'd0);
        chk("rst_flush_ctr", flush_count, 32'd0);

        // sequential fetch
        nRST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            step();
            chk("seq_valid", {31'b0, ifid_valid}, 32'd1);
            chk("seq_pc", ifid_pc, 32'(i * 4));
            chk("seq_npc", ifid_npc, 32'(i * 4 + 4));
            chk("seq_instr", ifid_instr, 32'hA500_0000 ^ 32'(i * 4));
        end
        chk("seq_addr", imemaddr, 32'h8);

        // stall holds pc and latch, ihit not consumed
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            step();
            chk("stall_addr", imemaddr, 32'h8);
            chk("stall_pc", ifid_pc, 32'h4);
            chk("stall_valid", {31'b0, ifid_valid}, 32'd1);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk("resume_pc", ifid_pc, 32'h8);
        chk("resume_addr", imemaddr, 32'hC);

        // flush during a miss, retargeted, then miss completes
        drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        step();
        chk("rw_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rw_addr", imemaddr, 32'hC);
        drive(1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
        step();
        chk("rw2_addr", imemaddr, 32'hC);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        chk("rw_done_addr", imemaddr, 32'h80);
        chk("rw_done_valid", {31'b0, ifid_valid}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk("tgt_pc", ifid_pc, 32'h80);
        chk("tgt_valid", {31'b0, ifid_valid}, 32'd1);

        // flush beats stall, redirect with hit
        drive(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
        step();
        chk("fs_valid", {31'b0, ifid_valid}, 32'd0);
        chk("fs_instr", ifid_instr, 32'h0);
        chk("fs_addr", imemaddr, 32'h100);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk("fs_tgt_pc", ifid_pc, 32'h100);

        // three more stalls, no hit
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            step();
        end
        chk("stall3_addr", imemaddr, 32'h104);

        // wrap at top of address space
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step();
        chk("wrap_addr0", imemaddr, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_npc", ifid_npc, 32'h0);
        chk("wrap_addr", imemaddr, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk("post_wrap_addr", imemaddr, 32'h4);

        // halt, then flush/hit ignored while halted
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        chk("halt_ren", {31'b0, imemREN}, 32'd0);
        chk("halt_valid", {31'b0, ifid_valid}, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
        step();
        chk("halted_addr", imemaddr, 32'h4);
        chk("halted_ren", {31'b0, imemREN}, 32'd0);

`ifdef FETCH_STATS_EN
        chk("stall_ctr", stall_cycles, 32'd5);
        chk("flush_ctr", flush_count, 32'd4);
`else
        chk("stall_ctr_off", stall_cycles, 32'd0);
        chk("flush_ctr_off", flush_count, 32'd0);
`endif

        // reset exits HALTED
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst2_ren", {31'b0, imemREN}, 32'd1);
        chk("rst2_addr", imemaddr, 32'h0);
        chk("rst2_stall_ctr", stall_cycles, 32'd0);
        chk("rst2_flush_ctr", flush_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
